// File: rtl/mux_arbiter.sv
// Round-robin arbiter owning the select of a shared N-input mux/dmux channel.
// Owners keep the channel while requesting, bounded by MAX_HOLD when others wait.
module mux_arbiter #(
    parameter int N_REQ    = 4,
    parameter int SEL_W    = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             busy
);

    localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_TOP = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;
    localparam bit PREEMPT = (MAX_HOLD > 0);

    typedef enum logic {IDLE, GRANT} state_e;

    state_e             state_q;
    logic [SEL_W-1:0]   ptr_q;
    logic [SEL_W-1:0]   sel_q;
    logic [N_REQ-1:0]   gnt_q;
    logic [HOLD_W-1:0]  hold_q;
    logic [HOLD_W-1:0]  hold_d;

    logic [SEL_W-1:0]   owner_next;
    logic [SEL_W-1:0]   base;
    logic [N_REQ-1:0]   cand;
    logic               win_found;
    logic [SEL_W-1:0]   win_idx;
    logic [N_REQ-1:0]   win_oh;
    logic               owner_req;

    function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] a, input int k);
        int s;
        s = int'(a) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return SEL_W'(s);
    endfunction

    // The owner is masked out so a preempt search can never re-pick it.
    always_comb begin
        owner_next = wrap_add(sel_q, 1);
        base       = (state_q == GRANT) ? owner_next : ptr_q;
        cand       = req & ~gnt_q;
        win_found  = 1'b0;
        win_idx    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (cand[wrap_add(base, k)]) begin
                win_found = 1'b1;
                win_idx   = wrap_add(base, k);
            end
        end
        win_oh    = N_REQ'(1) << win_idx;
        hold_d    = (hold_q == HOLD_TOP) ? hold_q : hold_q + 1'b1;
        owner_req = req[sel_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (win_found) begin
                        state_q <= GRANT;
                        gnt_q   <= win_oh;
                        sel_q   <= win_idx;
                        hold_q  <= '0;
                    end
                end
                GRANT: begin
                    if (!owner_req) begin
                        ptr_q  <= owner_next;
                        hold_q <= '0;
                        if (win_found) begin
                            gnt_q <= win_oh;
                            sel_q <= win_idx;
                        end else begin
                            gnt_q   <= '0;
                            state_q <= IDLE;
                        end
                    end else if (PREEMPT && hold_q == HOLD_TOP && win_found) begin
                        ptr_q  <= owner_next;
                        hold_q <= '0;
                        gnt_q  <= win_oh;
                        sel_q  <= win_idx;
                    end else begin
                        hold_q <= hold_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = |gnt_q;

endmodule

// File: doc/mux_arbiter.md
Name: mux_arbiter

Overview:
- Round-robin arbiter that shares one N-input mux/dmux channel between N requesters.
- Drives the channel's select index and a one-hot grant vector.
- A requester keeps the channel while its request stays high, subject to a hold-time limit when others are waiting.
- Sits directly in front of the shared mux/dmux tree.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- SEL_W, 2, select width; equals ceil(log2(N_REQ)).
- MAX_HOLD, 8, maximum consecutive grant cycles while another requester waits; 0 disables preemption.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  level request per requester; held high for as long as the channel is wanted.
- gnt  output  N_REQ  one-hot grant, registered; all zero when idle.
- sel  output  SEL_W  index of the current or last owner; drives the mux/dmux select.
- busy  output  1  high while any grant is active.

Behaviour:
- Reset (async, rst_n low):
  - gnt=0, sel=0, busy=0, state=IDLE, ptr=0, hold_cnt=0.
  - Takes effect immediately, including mid-grant; the first arbitration occurs at the first rising edge after rst_n rises.
- States: IDLE and GRANT.
- Priority search:
  - Pick the first i with req[i]=1, scanning ptr, ptr+1, ... N_REQ-1, 0, ... ptr-1 (wrap-around).
  - Combinational; result is registered.
- IDLE:
  - If any req is high at an edge, then next cycle: gnt one-hot at the winner, sel=winner, busy=1, hold_cnt=0, state=GRANT.
  - Latency from req to gnt is 1 cycle.
  - Otherwise gnt=0 and busy=0; sel keeps its last value so the datapath stays stable.
- GRANT, owner o:
  - Release: req[o]=0 at an edge.
    - Set ptr=o+1 (mod N_REQ).
    - If another req is high, grant the next winner (search from o+1) on that same edge; no idle bubble.
    - Otherwise go to IDLE with gnt=0 and busy=0.
  - Preempt: MAX_HOLD>0, hold_cnt==MAX_HOLD-1, req[o]=1, and another req is high.
    - Grant moves to the next winner searched from o+1; ptr=o+1.
    - The preempted requester re-enters normal rotation and needs no request toggle.
  - Otherwise: gnt unchanged. hold_cnt increments and saturates at MAX_HOLD-1 while no one else waits.
  - On any grant change, hold_cnt resets to 0.
- gnt is registered, so gnt[o] remains high during the cycle in which req[o] is first seen low. Requesters must not drive the channel after dropping req.
- Invariants:
  - gnt is always zero or one-hot.
  - busy == |gnt.
  - When busy=1, sel equals the index of the set gnt bit.
  - No requester waits more than (N_REQ-1)*MAX_HOLD + N_REQ cycles while continuously requesting, for MAX_HOLD>0.
- Simultaneous release by the owner and new requests: handled by the release rule. The owner is excluded from that search because its req is low.
- req bits for indices ≥ N_REQ do not exist; sel never exceeds N_REQ-1.

Test Plan:
- Reset, then req=0001 -> gnt=0001, sel=0, busy=1 one edge later. Drop req -> gnt=0000, busy=0 one edge later, sel holds 0.
- req=1111 held, MAX_HOLD=8 -> grants rotate 0,1,2,3,0, each owner exactly 8 cycles. gnt is never multi-hot and never zero between owners.
- Owner 2 holds; req[2] drops while req=1001 -> next grant is 3 (search from 3) with no idle cycle; ptr=3. Later tie between 0 and 3 from idle goes to 3.
- req=0100 alone for 20 cycles, MAX_HOLD=8 -> gnt=0100 throughout, hold_cnt saturates at 7. Assert req[0] -> grant moves to 0 on the next edge.
- MAX_HOLD=0, owner 1 holds 50 cycles with req=1111 -> no preemption. Release -> grant goes to 2.
- rst_n pulsed low mid-grant, asynchronously between edges -> gnt=0, busy=0, sel=0 immediately. After release with req=1010 -> gnt=0010.
